syslatch_wr_seq: RTL

- Bus-cycle initiator for the system latch. It generates the timed write strobes that set or clear individual latch bits.
- Queues 4-bit register codes. Code bit 3 is the data bit; code bits 2:0 are the latch bit index. This matches REG_* codes 0x0 to 0xF, e.g. 0x8 = REG_SHADOW, 0x0 = NOSHADOW.
- For each code, drives M68K_ADDR[4:1] and nBITW1 with programmable setup, strobe-width and hold timing.
- Keeps a mirror of the latch contents for testbench and debug readback.
- Sits between the CPU-side test or boot logic and the syslatch write port.

---
 rtl/syslatch_wr_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/syslatch_wr_seq.sv
// Bus-cycle initiator for the system latch: queues 4-bit register codes and
// replays each one as a timed M68K_ADDR / nBITW1 write, mirroring latch state.
module syslatch_wr_seq #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic                          CLK_24M,
  input  logic                          RESET,
  input  logic                          REQ_VALID,
  input  logic [3:0]                    REQ_CODE,
  output logic                          REQ_READY,
  output logic [3:0]                    M68K_ADDR,
  output logic                          nBITW1,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic [7:0]                    SLATCH_MIRROR
);

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LW   = PW + 1;
  localparam int unsigned CMAX = (SETUP_CYC > STROBE_CYC)
                                 ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                 : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  // Elaboration-time parameter sanity
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (SETUP_CYC < 1) begin : g_chk_setup
    $error("SETUP_CYC must be at least 1");
  end
  if (STROBE_CYC < 1) begin : g_chk_strobe
    $error("STROBE_CYC must be at least 1");
  end
  if (HOLD_CYC < 1) begin : g_chk_hold
    $error("HOLD_CYC must be at least 1");
  end

  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          push, pop;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    addr_q, addr_d;
  logic          nbitw1_q, nbitw1_d;
  logic          done_q, done_d;
  logic [7:0]    mirror_q, mirror_d;

  assign push = REQ_VALID & ready_q;

  // Queue occupancy and registered handshake/status flags
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    ready_d = (level_d != LW'(FIFO_DEPTH));
    busy_d  = (state_d != S_IDLE) || (level_d != LW'(0));
  end

  // Write sequencer next-state and outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    nbitw1_d = nbitw1_q;
    done_d   = 1'b0;
    mirror_d = mirror_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q != LW'(0)) begin
          pop     = 1'b1;
          addr_d  = fifo_mem[rd_ptr_q];
          cnt_d   = CW'(SETUP_CYC - 1);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == CW'(0)) begin
          nbitw1_d = 1'b0;
          cnt_d    = CW'(STROBE_CYC - 1);
          state_d  = S_STROBE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == CW'(0)) begin
          nbitw1_d              = 1'b1;
          done_d                = 1'b1;
          mirror_d[addr_q[2:0]] = addr_q[3];
          cnt_d                 = CW'(HOLD_CYC - 1);
          state_d               = S_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(0)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset aborts any write in flight and drops queued codes
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      nbitw1_q <= 1'b1;
      done_q   <= 1'b0;
      mirror_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      nbitw1_q <= nbitw1_d;
      done_q   <= done_d;
      mirror_q <= mirror_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge CLK_24M) begin
    if (!RESET && push) fifo_mem[wr_ptr_q] <= REQ_CODE;
  end

  assign REQ_READY     = ready_q;
  assign M68K_ADDR     = addr_q;
  assign nBITW1        = nbitw1_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign LEVEL         = level_q;
  assign SLATCH_MIRROR = mirror_q;

endmodule
